if_stage_fetch: RTL and testbench

- Instruction-fetch stage for the pipelined ARM core; the initiator/reader side of the combinational instruction memory.
- Owns the PC, drives the word address to instruction memory and captures the returned instruction into the IF/ID pipeline register.
- Handles hazard freeze and branch redirect/flush from later stages, and keeps a retired-fetch counter for debug.

---
 rtl/if_stage_fetch.sv | 102 ++++++++++
 tb/tb_if_stage_fetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and registers the returned word into the IF/ID pipeline register.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } fetch_mode_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] step_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  fetch_mode_e mode;
  logic [31:0] pc_p0;
  logic [31:0] pc_next_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic        vld_p1;
  logic [31:0] count_p1;

  // Branch outranks freeze so a redirect is never lost behind a stall.
  always_comb begin
    mode = RUN;
    if (branch_taken) begin
      mode = REDIRECT;
    end else if (freeze) begin
      mode = STALL;
    end
  end

  assign pc_next_p0 = step_pc(pc_p0);
  assign imem_addr  = pc_p0;

  // ---- stage p0: program counter ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_p0 <= RESET_PC;
    end else begin
      case (mode)
        REDIRECT: pc_p0 <= align_word(branch_addr);
        STALL:    pc_p0 <= pc_p0;
        default:  pc_p0 <= pc_next_p0;
      endcase
    end
  end

  // ---- stage p1: IF/ID register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_p1 <= '0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
      count_p1 <= '0;
    end else begin
      case (mode)
        REDIRECT: begin
          instr_p1 <= '0;
          pc_p1    <= '0;
          vld_p1   <= 1'b0;
        end
        STALL: begin
          instr_p1 <= instr_p1;
          pc_p1    <= pc_p1;
          vld_p1   <= vld_p1;
        end
        default: begin
          instr_p1 <= imem_instr;
          pc_p1    <= pc_next_p0;
          vld_p1   <= 1'b1;
          count_p1 <= count_p1 + 32'd1;
        end
      endcase
    end
  end

  assign if_instr    = instr_p1;
  assign if_pc       = pc_p1;
  assign if_valid    = vld_p1;
  assign fetch_count = count_p1;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch with a small ROM, a behavioural reference
// model checked every cycle, and hand-computed literal expectations.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_stage_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .fetch_count (fetch_count)
  );

  // 32-word ROM at 0x00..0x7C; everything else reads as zero.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (addr >= 32'd128) return 32'h0;
    if (idx == 32'd0) return 32'hE3A00014;
    return 32'hE2800000 + idx;
  endfunction

  assign imem_instr = rom_word(imem_addr);

  // Reference model: architectural state advanced once per rising edge.
  logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
  logic        m_vld;
  bit          model_ok = 0;

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      m_pc <= 32'h0; m_ifpc <= 32'h0; m_instr <= 32'h0; m_vld <= 1'b0; m_cnt <= 32'h0;
    end else if (branch_taken) begin
      m_pc <= branch_addr & 32'hFFFF_FFFC;
      m_ifpc <= 32'h0; m_instr <= 32'h0; m_vld <= 1'b0;
    end else if (!freeze) begin
      m_instr <= rom_word(m_pc);
      m_ifpc  <= m_pc + 32'd4;
      m_vld   <= 1'b1;
      m_cnt   <= m_cnt + 32'd1;
      m_pc    <= m_pc + 32'd4;
    end
    model_ok <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      check("m_imem_addr", imem_addr, m_pc);
      check("m_if_pc", if_pc, m_ifpc);
      check("m_if_instr", if_instr, m_instr);
      check("m_if_valid", {31'b0, if_valid}, {31'b0, m_vld});
      check("m_fetch_count", fetch_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    tick(); tick();
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_ifpc", if_pc, 32'h0);

    rst = 1'b1;
    tick();
    check("run1_addr", imem_addr, 32'h4);
    check("run1_instr", if_instr, 32'hE3A00014);
    check("run1_ifpc", if_pc, 32'h4);
    check("run1_valid", {31'b0, if_valid}, 32'h1);
    tick();
    check("run2_addr", imem_addr, 32'h8);
    tick();
    check("run3_addr", imem_addr, 32'hC);
    check("run3_count", fetch_count, 32'd3);

    // Freeze two cycles at pc=12
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("frz_addr", imem_addr, 32'hC);
      check("frz_ifpc", if_pc, 32'hC);
      check("frz_instr", if_instr, 32'hE2800002);
      check("frz_count", fetch_count, 32'd3);
    end
    freeze = 1'b0;
    tick();
    check("unfrz_ifpc", if_pc, 32'h10);
    check("unfrz_instr", if_instr, 32'hE2800003);
    check("unfrz_count", fetch_count, 32'd4);
    tick(); tick();
    check("pre_br_addr", imem_addr, 32'd24);

    // Branch to 0x40
    branch_taken = 1'b1; branch_addr = 32'h40;
    tick();
    branch_taken = 1'b0;
    check("br_addr", imem_addr, 32'h40);
    check("br_valid", {31'b0, if_valid}, 32'h0);
    check("br_instr", if_instr, 32'h0);
    check("br_count", fetch_count, 32'd6);
    tick();
    check("br_ifpc", if_pc, 32'h44);
    check("br_valid2", {31'b0, if_valid}, 32'h1);
    check("br_instr2", if_instr, 32'hE2800010);
    check("br_count2", fetch_count, 32'd7);

    // Branch with freeze, misaligned target
    branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h4B;
    tick();
    branch_taken = 1'b0; freeze = 1'b0;
    check("brfrz_addr", imem_addr, 32'h48);
    check("brfrz_valid", {31'b0, if_valid}, 32'h0);
    check("brfrz_ifpc", if_pc, 32'h0);
    check("brfrz_count", fetch_count, 32'd7);
    tick();
    check("brfrz_instr2", if_instr, 32'hE2800012);

    // Wrap at top of address space
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", imem_addr, 32'h0);
    check("wrap_ifpc", if_pc, 32'h0);
    check("wrap_instr", if_instr, 32'h0);
    check("wrap_valid", {31'b0, if_valid}, 32'h1);
    check("wrap_count", fetch_count, 32'd9);
    tick();
    check("wrap_count2", fetch_count, 32'd10);
    check("wrap_instr2", if_instr, 32'hE3A00014);

    // Mid-run reset with a simultaneous branch
    rst = 1'b0; branch_taken = 1'b1; branch_addr = 32'h80;
    tick();
    rst = 1'b1; branch_taken = 1'b0;
    check("mrst_addr", imem_addr, 32'h0);
    check("mrst_valid", {31'b0, if_valid}, 32'h0);
    check("mrst_count", fetch_count, 32'h0);
    tick();
    check("mrst_addr2", imem_addr, 32'h4);
    check("mrst_count2", fetch_count, 32'd1);

    // Mixed freeze/branch pattern, checked by the model only
    for (int i = 0; i < 24; i++) begin
      freeze       = (i % 5) == 2 || (i % 7) == 3;
      branch_taken = (i % 6) == 4;
      branch_addr  = 32'h10 + 32'(i) * 32'd3;
      tick();
    end
    freeze = 1'b0; branch_taken = 1'b0;
    tick(); tick();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
